// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks: Gray conversion
// and the depth / pointer-width relations derived from the address width.
package fifo_pkg;

    localparam int PTR_EXTRA_BITS = 1;
    localparam int CONV_W         = 32;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int ptr_width(input int addr_width);
        return addr_width + PTR_EXTRA_BITS;
    endfunction

    // Operands are zero-extended to CONV_W, which leaves both conversions exact
    // for any narrower pointer.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b = '0;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer, Gray export, and full / almost-full / level / overflow
// flags for the asynchronous FIFO, computed against the synchronised read pointer.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                  w_clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  w_ovf_clr,
    input  logic [ADDR_WIDTH:0]   r_ptr_gray,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic                  w_push,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_overflow
);

    localparam int PW    = ptr_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Full when the Gray pointers differ in exactly their top two bits.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
    localparam logic [PW-1:0] AF_LEVEL  = PW'(AF_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
        $error("wptr_full_ctrl: AF_THRESH must lie in 1..DEPTH");
    end

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin;

    sync_2ff #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk (w_clk),
        .rst (rst),
        .d   (r_ptr_gray),
        .q   (rq2)
    );

    always_comb begin
        w_push  = w_en & ~full_q;
        wbin_d  = wbin_q + PW'(w_push);
        wgray_d = PW'(bin2gray(CONV_W'(wbin_d)));
        rbin    = PW'(gray2bin(CONV_W'(rq2)));
        full_d  = (wgray_d == (rq2 ^ FULL_MASK));
        level_d = wbin_d - rbin;
        af_d    = (level_d >= AF_LEVEL);
        // A write attempt against a full FIFO overrides a same-cycle clear.
        ovf_d   = (w_en & full_q) | (ovf_q & ~w_ovf_clr);
    end

    always_ff @(posedge w_clk or negedge rst) begin
        if (!rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_addr        = wbin_q[ADDR_WIDTH-1:0];
    assign w_ptr_gray    = wgray_q;
    assign w_full        = full_q;
    assign w_almost_full = af_q;
    assign w_level       = level_q;
    assign w_overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed scenarios plus random traffic, checked
// every cycle against a write/read occupancy-count model.
module tb_wptr_full_ctrl;

    localparam int AW    = 3;
    localparam int AF    = 6;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;

    logic          w_clk = 1'b0;
    logic          rst   = 1'b0;
    logic          w_en  = 1'b0;
    logic          w_ovf_clr = 1'b0;
    logic [AW:0]   r_ptr_gray;
    logic [AW-1:0] w_addr;
    logic [AW:0]   w_ptr_gray;
    logic          w_push;
    logic          w_full;
    logic          w_almost_full;
    logic [AW:0]   w_level;
    logic          w_overflow;

    int rcnt = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;

    // Model state: occupancy arithmetic on plain counts.
    int mw, mq1, mq2, mlevel;
    bit mfull, maf, movf;
    int m_push, m_wn, m_lvl;

    function automatic logic [AW:0] to_gray(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    assign r_ptr_gray = to_gray(rcnt);

    wptr_full_ctrl #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF)
    ) dut (
        .w_clk         (w_clk),
        .rst           (rst),
        .w_en          (w_en),
        .w_ovf_clr     (w_ovf_clr),
        .r_ptr_gray    (r_ptr_gray),
        .w_addr        (w_addr),
        .w_ptr_gray    (w_ptr_gray),
        .w_push        (w_push),
        .w_full        (w_full),
        .w_almost_full (w_almost_full),
        .w_level       (w_level),
        .w_overflow    (w_overflow)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge w_clk or negedge rst) begin
        if (!rst) begin
            mw = 0; mq1 = 0; mq2 = 0; mlevel = 0;
            mfull = 0; maf = 0; movf = 0;
        end else begin
            m_push = (w_en && !mfull) ? 1 : 0;
            m_wn   = (mw + m_push) % PMOD;
            m_lvl  = (m_wn - mq2 + PMOD) % PMOD;
            movf   = (w_en && mfull) || (movf && !w_ovf_clr);
            mfull  = (m_lvl == DEPTH);
            maf    = (m_lvl >= AF);
            mlevel = m_lvl;
            mq2    = mq1;
            mq1    = rcnt;
            mw     = m_wn;
        end
    end

    always @(negedge w_clk) begin
        if (chk_en) begin
            chk("m_addr",  w_addr,        mw % DEPTH);
            chk("m_gray",  w_ptr_gray,    to_gray(mw));
            chk("m_full",  w_full,        mfull);
            chk("m_af",    w_almost_full, maf);
            chk("m_level", w_level,       mlevel);
            chk("m_ovf",   w_overflow,    movf);
            chk("m_push",  w_push,        w_en && !mfull);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    logic [AW:0] prev_gray;
    int msb_toggles;
    int hist[$];

    initial begin
        step(2);
        chk("rst_addr",  w_addr, 0);
        chk("rst_level", w_level, 0);
        chk("rst_full",  w_full, 0);
        rst = 1'b1;

        // Fill from empty
        w_en = 1'b1;
        #1;
        chk("t1_push_first", w_push, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1);
            chk("t1_addr", w_addr, i % DEPTH);
        end
        chk("t1_full",  w_full, 1);
        chk("t1_gray",  w_ptr_gray, 4'b1100);
        chk("t1_level", w_level, 8);

        // Overflow behaviour
        step(2);
        chk("t2_addr_hold", w_addr, 0);
        chk("t2_gray_hold", w_ptr_gray, 4'b1100);
        chk("t2_push", w_push, 0);
        chk("t2_ovf",  w_overflow, 1);
        w_en = 1'b0;
        step(1);
        chk("t2_ovf_sticky", w_overflow, 1);
        w_ovf_clr = 1'b1;
        step(1);
        chk("t2_ovf_clr", w_overflow, 0);
        w_en = 1'b1;
        step(1);
        chk("t2_set_wins", w_overflow, 1);
        w_en = 1'b0;
        w_ovf_clr = 1'b0;

        // Read advance reaches the flags on the third edge
        rcnt = 1;
        step(1);
        chk("t3_full_e1",  w_full, 1);
        chk("t3_level_e1", w_level, 8);
        step(1);
        chk("t3_full_e2",  w_full, 1);
        chk("t3_level_e2", w_level, 8);
        step(1);
        chk("t3_full_e3",  w_full, 0);
        chk("t3_level_e3", w_level, 7);

        // Almost-full threshold from empty
        rcnt = 8;
        step(3);
        chk("t4_empty", w_level, 0);
        w_en = 1'b1;
        step(5);
        chk("t4_af5",  w_almost_full, 0);
        chk("t4_lvl5", w_level, 5);
        step(1);
        chk("t4_af6",  w_almost_full, 1);
        chk("t4_lvl6", w_level, 6);
        w_en = 1'b0;

        // Three laps with the read pointer trailing by three cycles
        rcnt = mw;
        step(3);
        w_en = 1'b1;
        msb_toggles = 0;
        hist.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            prev_gray = w_ptr_gray;
            step(1);
            chk("t5_gray_1bit", $countones(prev_gray ^ w_ptr_gray), 1);
            chk("t5_nofull", w_full, 0);
            if (prev_gray[AW] != w_ptr_gray[AW]) msb_toggles++;
            hist.push_back(mw);
            if (hist.size() > 3) rcnt = hist.pop_front();
        end
        chk("t5_msb_laps", msb_toggles, 3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            w_en      = ($urandom_range(0, 9) < 7);
            w_ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0 && rcnt != mw) rcnt = (rcnt + 1) % PMOD;
            step(1);
        end
        w_ovf_clr = 1'b0;

        // Asynchronous reset mid-burst
        w_en = 1'b1;
        step(3);
        #2;
        rst  = 1'b0;
        rcnt = 0;
        #1;
        chk("t6_addr",  w_addr, 0);
        chk("t6_gray",  w_ptr_gray, 0);
        chk("t6_full",  w_full, 0);
        chk("t6_af",    w_almost_full, 0);
        chk("t6_level", w_level, 0);
        chk("t6_ovf",   w_overflow, 0);
        chk("t6_push",  w_push, 1);
        step(1);
        rst = 1'b1;
        #1;
        chk("t6_first_addr", w_addr, 0);
        step(1);
        chk("t6_second_addr", w_addr, 1);
        w_en = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
